// File: rtl/ahb_dmem_bridge.sv
// ---------------------------------------------------------------------------
// ahb_dmem_bridge
//
// AHB-Lite slave front end for the data memory. It accepts pipelined
// address/data phases and turns them into word-aligned memory strobes.
// Sub-word writes are merged into the full memory word in a single cycle:
// the memory word is read, the selected byte lanes are replaced from HWDATA,
// and the result goes back through the memory's full-word write port.
// Illegal accesses (bad size, misaligned, out of range) get a two-cycle
// ERROR response and never touch the memory.
//
// Parameters:
//   BASE_ADDR  bus address mapped to memory byte 0
//   MEM_BYTES  memory size in bytes (multiple of 4)
//
// Ports:
//   clk, reset_n            clock (rising edge), async active-low reset
//   HSEL, HADDR, HTRANS,    AHB-Lite address phase
//   HWRITE, HSIZE, HREADY
//   HWDATA                  AHB-Lite data-phase write data
//   HRDATA, HREADYOUT,      AHB-Lite slave response
//   HRESP
//   mem_sel, mem_read,      memory strobes (mem_sel drives HSEL2)
//   mem_write
//   address_ram             word-aligned memory byte offset
//   write_data              merged write word
//   read_data               combinational memory read word
//
// Build option:
//   AHB_DMEM_RDREG_EN  when defined, reads take one wait state (RD -> RD2)
//                      and HRDATA comes from a register, removing the
//                      combinational memory-to-HRDATA path.
// ---------------------------------------------------------------------------
module ahb_dmem_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic        mem_sel,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] address_ram,
    output logic [31:0] write_data,
    input  logic [31:0] read_data
);

    // S_RD is the single read data phase in the default build and the
    // first (memory access) cycle of a read when AHB_DMEM_RDREG_EN is set.
    // S_RD2 is only reachable with AHB_DMEM_RDREG_EN.
    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_ERR1,
        S_ERR2,
        S_RD2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] off_q, off_d;
    logic [1:0]  size_q, size_d;

`ifdef AHB_DMEM_RDREG_EN
    logic [31:0] rdata_q, rdata_d;
`endif

    // Address-phase decode
    logic        accept;
    logic [31:0] off_in;
    logic        acc_err;
    logic        can_accept;
    logic        take;

    // HTRANS[0] only distinguishes BUSY/SEQ, which this slave treats
    // identically to IDLE/NONSEQ respectively.
    logic        unused_htrans0;
    assign unused_htrans0 = HTRANS[0];

    assign accept = HSEL && HREADY && HTRANS[1];
    assign off_in = HADDR - BASE_ADDR;
    assign acc_err = (HSIZE > 3'd2)
                   || ((HSIZE == 3'd1) && HADDR[0])
                   || ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00))
                   || (off_in >= MEM_BYTES);

    // Write merge: replace the addressed byte lanes of the current word.
    logic [3:0]  lane_en;
    logic [31:0] merged;

    always_comb begin
        lane_en = '0;
        case (size_q)
            2'd0:    lane_en[off_q[1:0]] = 1'b1;
            2'd1:    lane_en = off_q[1] ? 4'b1100 : 4'b0011;
            default: lane_en = '1;
        endcase
        for (int unsigned i = 0; i < 4; i++) begin
            merged[8*i +: 8] = lane_en[i] ? HWDATA[8*i +: 8] : read_data[8*i +: 8];
        end
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            off_q   <= '0;
            size_q  <= '0;
`ifdef AHB_DMEM_RDREG_EN
            rdata_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            off_q   <= off_d;
            size_q  <= size_d;
`ifdef AHB_DMEM_RDREG_EN
            rdata_q <= rdata_d;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // A new address phase overlaps any data phase that completes
        // this cycle with HREADYOUT high.
        can_accept = 1'b1;
        case (state_q)
            S_ERR1:  can_accept = 1'b0;
`ifdef AHB_DMEM_RDREG_EN
            S_RD:    can_accept = 1'b0;
`endif
            default: can_accept = 1'b1;
        endcase
        take = can_accept && accept;

        off_d  = take ? off_in : off_q;
        size_d = take ? HSIZE[1:0] : size_q;

        state_d = S_IDLE;
        if (state_q == S_ERR1) begin
            state_d = S_ERR2;
`ifdef AHB_DMEM_RDREG_EN
        end else if (state_q == S_RD) begin
            state_d = S_RD2;
`endif
        end else if (take) begin
            if (acc_err) begin
                state_d = S_ERR1;
            end else if (HWRITE) begin
                state_d = S_WR;
            end else begin
                state_d = S_RD;
            end
        end

`ifdef AHB_DMEM_RDREG_EN
        rdata_d = (state_q == S_RD) ? read_data : rdata_q;
`endif
    end

    // -----------------------------------------------------------------------
    // Output logic
    // -----------------------------------------------------------------------
    always_comb begin
        HRDATA      = '0;
        HREADYOUT   = 1'b1;
        HRESP       = 1'b0;
        mem_sel     = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        address_ram = '0;
        write_data  = '0;
        case (state_q)
            S_RD: begin
                mem_sel     = 1'b1;
                mem_read    = 1'b1;
                address_ram = {off_q[31:2], 2'b00};
`ifdef AHB_DMEM_RDREG_EN
                HREADYOUT   = 1'b0;
`else
                HRDATA      = read_data;
`endif
            end
            S_WR: begin
                mem_sel     = 1'b1;
                mem_read    = 1'b1;
                mem_write   = 1'b1;
                address_ram = {off_q[31:2], 2'b00};
                write_data  = merged;
            end
            S_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
            end
            S_ERR2: begin
                HRESP = 1'b1;
            end
`ifdef AHB_DMEM_RDREG_EN
            S_RD2: begin
                HRDATA = rdata_q;
            end
`endif
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_ahb_dmem_bridge.sv
// ---------------------------------------------------------------------------
// tb_ahb_dmem_bridge
//
// Pipelined AHB-Lite master driving directed and random transfers into
// ahb_dmem_bridge, backed by a simple word memory. Each accepted transfer is
// pushed to a scoreboard queue; a monitor pops it when the data phase
// completes and checks the response and memory strobes against a byte-level
// reference model of the memory.
// ---------------------------------------------------------------------------
module tb_ahb_dmem_bridge;

    localparam logic [31:0] BASE = 32'h2000_0000;
    localparam int          MEMB = 1024;

`ifdef AHB_DMEM_RDREG_EN
    localparam int RD_WAITS = 1;
`else
    localparam int RD_WAITS = 0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic        mem_sel;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] address_ram;
    logic [31:0] write_data;
    logic [31:0] read_data;

    always #5 clk = ~clk;

    // Single slave on the bus: bus-level ready is this slave's ready.
    assign HREADY = HREADYOUT;

    ahb_dmem_bridge #(
        .BASE_ADDR (BASE),
        .MEM_BYTES (MEMB)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .HSEL        (HSEL),
        .HADDR       (HADDR),
        .HTRANS      (HTRANS),
        .HWRITE      (HWRITE),
        .HSIZE       (HSIZE),
        .HWDATA      (HWDATA),
        .HREADY      (HREADY),
        .HRDATA      (HRDATA),
        .HREADYOUT   (HREADYOUT),
        .HRESP       (HRESP),
        .mem_sel     (mem_sel),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .address_ram (address_ram),
        .write_data  (write_data),
        .read_data   (read_data)
    );

    // Physical memory behind the bridge (combinational read, clocked write).
    logic [31:0] phys [MEMB/4] = '{default: '0};
    assign read_data = phys[address_ram[9:2]];
    always @(posedge clk) begin
        if (mem_sel && mem_write) phys[address_ram[9:2]] <= write_data;
    end

    // Reference model: plain byte array.
    logic [7:0] refm [MEMB] = '{default: '0};

    typedef struct packed {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        has_const;
        logic [31:0] const_val;
    } xfer_t;

    typedef struct packed {
        logic        wr;
        logic        err;
        logic [31:0] off;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic        has_const;
        logic [31:0] const_val;
    } exp_t;

    exp_t  sb_q[$];
    xfer_t stim[$];

    int n_checks = 0;
    int n_pass   = 0;
    int waits    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic ref_err(input logic [31:0] addr, input logic [2:0] size);
        logic [31:0] off;
        off = addr - BASE;
        if (size > 3'd2) return 1'b1;
        if ((addr % (32'd1 << size)) != 32'd0) return 1'b1;
        return (off >= MEMB);
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] off);
        int w;
        w = int'(off) & ~3;
        return {refm[w+3], refm[w+2], refm[w+1], refm[w]};
    endfunction

    function automatic xfer_t mk(input logic wr, input logic [2:0] size, input logic [31:0] off,
                                 input logic [31:0] wdata, input logic has_c, input logic [31:0] cval);
        xfer_t x;
        x.sel = 1'b1; x.trans = 2'b10; x.wr = wr; x.size = size; x.addr = BASE + off;
        x.wdata = wdata; x.has_const = has_c; x.const_val = cval;
        return x;
    endfunction

    function automatic xfer_t mk_idle(input logic sel, input logic [1:0] trans);
        xfer_t x;
        x = mk(1'b1, 3'd2, 32'h0, $urandom, 1'b0, 32'h0);
        x.sel = sel; x.trans = trans;
        return x;
    endfunction

    function automatic xfer_t gen_rand();
        xfer_t x;
        logic [31:0] off;
        logic [2:0]  size;
        size = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        off  = 32'($urandom_range(0, MEMB + 15));
        if ($urandom_range(0, 3) != 0 && size <= 3'd2) off = off & ~((32'd1 << size) - 32'd1);
        x = mk(1'($urandom), size, off, $urandom, 1'b0, 32'h0);
        if ($urandom_range(0, 19) == 0) x.addr = $urandom;
        x.sel = ($urandom_range(0, 7) != 0);
        case ($urandom_range(0, 9))
            0:       x.trans = 2'b00;
            1:       x.trans = 2'b01;
            2, 3:    x.trans = 2'b11;
            default: x.trans = 2'b10;
        endcase
        return x;
    endfunction

    task automatic drive(input xfer_t x);
        HSEL = x.sel; HADDR = x.addr; HTRANS = x.trans; HWRITE = x.wr; HSIZE = x.size;
    endtask

    task automatic push(input xfer_t x);
        exp_t e;
        e.wr = x.wr; e.err = ref_err(x.addr, x.size); e.off = x.addr - BASE; e.size = x.size;
        e.wdata = x.wdata; e.has_const = x.has_const; e.const_val = x.const_val;
        sb_q.push_back(e);
    endtask

    // Runs the stim queue as a pipelined master. Call at posedge + 1.
    task automatic run_stim();
        xfer_t cur;
        logic  rdy;
        int    stall;
        stall = 0;
        cur = stim.pop_front();
        drive(cur);
        forever begin
            @(negedge clk);
            rdy = HREADYOUT;
            @(posedge clk);
            #1;
            if (rdy) begin
                stall = 0;
                if (cur.sel && cur.trans[1]) push(cur);
                HWDATA = cur.wdata;
                if (stim.size() == 0) begin
                    drive(mk_idle(1'b0, 2'b00));
                    break;
                end
                cur = stim.pop_front();
                drive(cur);
            end else begin
                stall++;
                if (stall > 8) begin
                    check("stall_timeout", 32'(stall), 32'd0);
                    drive(mk_idle(1'b0, 2'b00));
                    break;
                end
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
        #1;
        check("drain_empty", 32'(sb_q.size()), 32'd0);
    endtask

    // -----------------------------------------------------------------------
    // Monitor / scoreboard
    // -----------------------------------------------------------------------
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] exp_w;
        int          nb;
        int          b;
        if (!reset_n) begin
            sb_q.delete();
            waits = 0;
        end else if (sb_q.size() == 0) begin
            check("idle_strobes", {29'd0, mem_sel, mem_read, mem_write}, 32'd0);
            check("idle_resp", {30'd0, HREADYOUT, HRESP}, 32'd2);
        end else begin
            e = sb_q[0];
            if (!HREADYOUT) begin
                waits++;
                check("wait_hresp", {31'd0, HRESP}, {31'd0, e.err});
                check("wait_no_write", {31'd0, mem_write}, 32'd0);
            end else begin
                void'(sb_q.pop_front());
                check("wait_count", 32'(waits), e.err ? 32'd1 : (e.wr ? 32'd0 : 32'(RD_WAITS)));
                waits = 0;
                check("hresp", {31'd0, HRESP}, {31'd0, e.err});
                if (e.err) begin
                    check("err_strobes", {29'd0, mem_sel, mem_read, mem_write}, 32'd0);
                end else if (e.wr) begin
                    nb = 1 << e.size;
                    for (int i = 0; i < nb; i++) begin
                        b = int'(e.off) + i;
                        refm[b] = e.wdata[8*(b % 4) +: 8];
                    end
                    exp_w = ref_word(e.off);
                    check("wr_strobes", {29'd0, mem_sel, mem_read, mem_write}, 32'd7);
                    check("wr_addr", address_ram, e.off & ~32'd3);
                    check("wr_data", write_data, exp_w);
                end else begin
                    check("rd_data", HRDATA, ref_word(e.off));
                    if (e.has_const) check("rd_const", HRDATA, e.const_val);
`ifdef AHB_DMEM_RDREG_EN
                    check("rd2_strobes", {29'd0, mem_sel, mem_read, mem_write}, 32'd0);
`else
                    check("rd_strobes", {29'd0, mem_sel, mem_read, mem_write}, 32'd6);
                    check("rd_addr", address_ram, e.off & ~32'd3);
`endif
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin
        xfer_t x;
        reset_n = 1'b0;
        drive(mk_idle(1'b0, 2'b00));
        HWDATA = '0;
        #1;
        check("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
        check("rst_hresp", {31'd0, HRESP}, 32'd0);
        check("rst_hrdata", HRDATA, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed sequence
        stim.push_back(mk(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0));
        stim.push_back(mk(1'b0, 3'd2, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF));
        stim.push_back(mk(1'b1, 3'd2, 32'h20, 32'h11223344, 1'b0, 32'h0));
        stim.push_back(mk(1'b1, 3'd0, 32'h21, 32'h0000AA00, 1'b0, 32'h0));
        stim.push_back(mk(1'b1, 3'd1, 32'h22, 32'hBBCC0000, 1'b0, 32'h0));
        stim.push_back(mk(1'b0, 3'd2, 32'h20, 32'h0, 1'b1, 32'hBBCCAA44));
        stim.push_back(mk(1'b1, 3'd1, 32'h03, 32'hFFFFFFFF, 1'b0, 32'h0));
        stim.push_back(mk(1'b0, 3'd2, 32'h00, 32'h0, 1'b1, 32'h0));
        stim.push_back(mk(1'b0, 3'd2, MEMB, 32'h0, 1'b0, 32'h0));
        stim.push_back(mk(1'b1, 3'd2, MEMB - 4, 32'h0BAD_F00D, 1'b0, 32'h0));
        stim.push_back(mk(1'b0, 3'd2, MEMB - 4, 32'h0, 1'b1, 32'h0BAD_F00D));
        stim.push_back(mk(1'b1, 3'd2, 32'h40, 32'h5A5A_1234, 1'b0, 32'h0));
        stim.push_back(mk(1'b0, 3'd2, 32'h40, 32'h0, 1'b1, 32'h5A5A_1234));
        stim.push_back(mk_idle(1'b1, 2'b00));
        stim.push_back(mk_idle(1'b1, 2'b01));
        stim.push_back(mk_idle(1'b0, 2'b10));
        stim.push_back(mk(1'b0, 3'd3, 32'h40, 32'h0, 1'b0, 32'h0));
        x = mk(1'b0, 3'd2, 32'h0, 32'h0, 1'b0, 32'h0);
        x.addr = BASE - 32'd4;
        stim.push_back(x);
        stim.push_back(mk(1'b0, 3'd0, 32'h43, 32'h0, 1'b0, 32'h0));
        stim.push_back(mk(1'b1, 3'd2, 32'h80, 32'hCAFE0001, 1'b0, 32'h0));
        for (int i = 0; i < 400; i++) stim.push_back(gen_rand());
        stim.push_back(mk_idle(1'b0, 2'b00));
        run_stim();
        drain();

        // Reset during a write data phase: write must be abandoned.
        @(posedge clk);
        #1;
        x = mk(1'b1, 3'd2, 32'h80, 32'h7777_8888, 1'b0, 32'h0);
        drive(x);
        @(posedge clk);
        #1;
        push(x);
        HWDATA = x.wdata;
        drive(mk_idle(1'b0, 2'b00));
        #2;
        check("pre_rst_mem_write", {31'd0, mem_write}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("arst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
        check("arst_hresp", {31'd0, HRESP}, 32'd0);
        check("arst_hrdata", HRDATA, 32'd0);
        check("arst_strobes", {29'd0, mem_sel, mem_read, mem_write}, 32'd0);
        check("arst_addr", address_ram, 32'd0);
        check("arst_wdata", write_data, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        stim.push_back(mk(1'b0, 3'd2, 32'h80, 32'h0, 1'b1, 32'hCAFE0001));
        stim.push_back(mk_idle(1'b0, 2'b00));
        run_stim();
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
